pir_stim_sequencer: RTL and testbench

Synthesizable, programmable stimulus sequencer for the motion-detection datapath. It drives the turn, stop_alarm and N PIR-sensor level buses from a step table. Each table entry holds one output vector plus a hold duration in clock cycles. It replaces the fixed-delay testbench stimulus, so the same scenarios can run on FPGA or in simulation, with a loop mode and a channel count set by parameters.

---
 rtl/pir_stim_pkg.sv | 25 ++
 rtl/pir_stim_mem.sv | 24 ++
 rtl/pir_stim_sequencer.sv | 139 +++++++++++++
 tb/tb_pir_stim_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pir_stim_pkg.sv
// Shared types and step-entry field layout for the PIR stimulus sequencer.
// A step packs {dur, turn, stop_alarm, ch[NUM_CH-1..0]} with channel 0 in the LSBs.
package pir_stim_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam int LOOP_CNT_W = 8;

  function automatic int ch_lsb(input int ch, input int data_w);
    return ch * data_w;
  endfunction

  function automatic int stop_alarm_bit(input int num_ch, input int data_w);
    return num_ch * data_w;
  endfunction

  function automatic int turn_bit(input int num_ch, input int data_w);
    return num_ch * data_w + 1;
  endfunction

  function automatic int dur_lsb(input int num_ch, input int data_w);
    return num_ch * data_w + 2;
  endfunction

endpackage

// File: rtl/pir_stim_mem.sv
// Step table: one synchronous write port, one asynchronous read port, no reset.
module pir_stim_mem #(
  parameter int DEPTH  = 16,
  parameter int STEP_W = 39,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [STEP_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [STEP_W-1:0] rdata
);

  logic [STEP_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read is combinational, so a write on the entry edge still yields the old entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/pir_stim_sequencer.sv
// Programmable step-table stimulus sequencer driving turn, stop_alarm and PIR levels.
// Each step holds its outputs for max(dur,1) cycles; optional looping with pass count.
module pir_stim_sequencer
  import pir_stim_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 7,
  parameter int DEPTH   = 16,
  parameter int DUR_W   = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int STEP_W = DUR_W + 2 + NUM_CH*DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [AW-1:0]            prog_addr,
  input  logic [STEP_W-1:0]        prog_data,
  input  logic [AW:0]              num_steps,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     abort,
  output logic                     turn,
  output logic                     stop_alarm,
  output logic [NUM_CH*DATA_W-1:0] pir_sensor,
  output logic [AW-1:0]            step_idx,
  output logic                     step_strobe,
  output logic                     busy,
  output logic                     done,
  output logic [LOOP_CNT_W-1:0]    loop_cnt
);

  localparam int TURN_B = turn_bit(NUM_CH, DATA_W);
  localparam int STOP_B = stop_alarm_bit(NUM_CH, DATA_W);
  localparam int DUR_L  = dur_lsb(NUM_CH, DATA_W);

  state_t                         state, state_n;
  logic [DUR_W-1:0]               cnt;
  logic [AW-1:0]                  n_last;
  logic                           loop_r;
  logic [AW-1:0]                  rd_addr;
  logic [STEP_W-1:0]              rd_data;
  logic [DUR_W-1:0]               rd_dur;
  logic [NUM_CH-1:0][DATA_W-1:0]  rd_ch;
  logic [AW:0]                    ns_clamp;
  logic idle_like, expire, is_last;
  logic do_start, do_zero, do_next, do_wrap, do_finish, load;

  pir_stim_mem #(.DEPTH(DEPTH), .STEP_W(STEP_W)) u_mem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign rd_ch[c] = rd_data[ch_lsb(c, DATA_W) +: DATA_W];
  end
  assign rd_dur = rd_data[DUR_L +: DUR_W];

  // Abort outranks every other event; a start is only honoured outside HOLD.
  always_comb begin
    idle_like = (state != HOLD);
    expire    = (state == HOLD) && (cnt == '0);
    is_last   = (step_idx == n_last);
    do_start  = !abort && idle_like && start && (num_steps != '0);
    do_zero   = !abort && idle_like && start && (num_steps == '0);
    do_next   = !abort && expire && !is_last;
    do_wrap   = !abort && expire && is_last && loop_r;
    do_finish = !abort && expire && is_last && !loop_r;
    load      = do_start | do_next | do_wrap;
    rd_addr   = do_next ? step_idx + 1'b1 : '0;
    ns_clamp  = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
  end

  always_comb begin
    state_n = state;
    if (abort)                      state_n = IDLE;
    else if (do_start || do_wrap)   state_n = HOLD;
    else if (do_zero || do_finish)  state_n = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      turn        <= 1'b0;
      stop_alarm  <= 1'b0;
      pir_sensor  <= '0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      loop_cnt    <= '0;
      cnt         <= '0;
      n_last      <= '0;
      loop_r      <= 1'b0;
    end else begin
      step_strobe <= load;
      if (abort) begin
        turn       <= 1'b0;
        stop_alarm <= 1'b0;
        pir_sensor <= '0;
        step_idx   <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
        loop_cnt   <= '0;
      end else begin
        if (do_start) begin
          n_last   <= AW'(ns_clamp - 1'b1);
          loop_r   <= loop_en;
          loop_cnt <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
        end
        if (do_zero || do_finish) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        if (do_wrap && loop_cnt != '1) loop_cnt <= loop_cnt + 1'b1;
        // Counter holds cycles remaining after this one; dur=0 behaves as 1.
        if (load) begin
          turn       <= rd_data[TURN_B];
          stop_alarm <= rd_data[STOP_B];
          pir_sensor <= rd_ch;
          step_idx   <= rd_addr;
          cnt        <= (rd_dur == '0) ? '0 : rd_dur - 1'b1;
        end else if (state == HOLD && cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pir_stim_sequencer.sv
// Self-checking bench: checkpoint table for the reference scenario, hand sequences for
// abort/reset/write corners, and randomized runs against a timeline model.
module tb_pir_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst, prog_we, loop_en, start, abort;
  logic [3:0]  prog_addr;
  logic [38:0] prog_data;
  logic [4:0]  num_steps;
  logic        turn, stop_alarm, step_strobe, busy, done;
  logic [20:0] pir_sensor;
  logic [3:0]  step_idx;
  logic [7:0]  loop_cnt;

  pir_stim_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .num_steps(num_steps), .loop_en(loop_en), .start(start), .abort(abort),
    .turn(turn), .stop_alarm(stop_alarm), .pir_sensor(pir_sensor), .step_idx(step_idx),
    .step_strobe(step_strobe), .busy(busy), .done(done), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        turn;
    logic        stop;
    logic [20:0] pir;
    logic [3:0]  idx;
    logic        strobe;
    logic        busy;
    logic        done;
    logic [7:0]  lcnt;
  } obs_t;

  typedef struct {
    int   t;
    obs_t e;
  } vec_t;

  int          n_chk = 0, n_fail = 0;
  int          m_dur [16];
  bit          m_turn[16], m_stop[16];
  logic [20:0] m_pir [16];
  vec_t        v1[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(bit tn, bit sa, logic [20:0] p, int idx, bit sb, bit bz, bit dn, int lc);
    obs_t o;
    o.turn = tn; o.stop = sa; o.pir = p; o.idx = 4'(idx);
    o.strobe = sb; o.busy = bz; o.done = dn; o.lcnt = 8'(lc);
    return o;
  endfunction

  function automatic obs_t get_obs();
    return mk(turn, stop_alarm, pir_sensor, int'(step_idx), step_strobe, busy, done, int'(loop_cnt));
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic prog(int a, int dur, bit tn, bit sa, int c0, int c1, int c2);
    prog_we = 1'b1; prog_addr = 4'(a);
    prog_data = {16'(dur), tn, sa, 7'(c2), 7'(c1), 7'(c0)};
    tick();
    prog_we = 1'b0;
    m_dur[a] = dur; m_turn[a] = tn; m_stop[a] = sa; m_pir[a] = {7'(c2), 7'(c1), 7'(c0)};
  endtask

  // Expected outputs t cycles after the start edge, laid out as a timeline of step lengths.
  function automatic obs_t model(int t, int ns, bit lp);
    int n, p, u, off, pass, acc, k, len;
    bit found;
    obs_t o;
    n = (ns > 16) ? 16 : ns;
    p = 0;
    for (int i = 0; i < n; i++) p += (m_dur[i] == 0) ? 1 : m_dur[i];
    u = t - 1;
    if (!lp && u >= p)
      return mk(m_turn[n-1], m_stop[n-1], m_pir[n-1], n-1, 1'b0, 1'b0, 1'b1, 0);
    off = lp ? u % p : u;
    pass = lp ? u / p : 0;
    acc = 0; k = 0; found = 1'b0;
    for (int i = 0; i < n; i++) begin
      len = (m_dur[i] == 0) ? 1 : m_dur[i];
      if (!found) begin
        if (off < acc + len) begin k = i; found = 1'b1; end
        else acc += len;
      end
    end
    o = mk(m_turn[k], m_stop[k], m_pir[k], k, off == acc, 1'b1, 1'b0, (pass > 255) ? 255 : pass);
    return o;
  endfunction

  task automatic run(int ns, bit lp, int ncyc, string name, int inj);
    abort = 1'b1; tick(); abort = 1'b0;
    num_steps = 5'(ns); loop_en = lp; start = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      tick();
      start = (t == inj);
      chk(name, 64'(get_obs()), 64'(model(t, ns, lp)));
    end
    start = 1'b0;
  endtask

  initial begin
    logic [20:0] s0p, s1p;
    int vi, n;
    s0p = 21'(56 << 14);
    s1p = 21'((56 << 14) | 29);
    v1[0] = '{1,   mk(1, 0, s0p,  0, 1, 1, 0, 0)};
    v1[1] = '{5,   mk(1, 0, s0p,  0, 0, 1, 0, 0)};
    v1[2] = '{6,   mk(1, 0, s1p,  1, 1, 1, 0, 0)};
    v1[3] = '{105, mk(1, 0, s1p,  1, 0, 1, 0, 0)};
    v1[4] = '{106, mk(0, 1, 21'd0, 2, 1, 1, 0, 0)};
    v1[5] = '{115, mk(0, 1, 21'd0, 2, 0, 1, 0, 0)};
    v1[6] = '{116, mk(0, 1, 21'd0, 2, 0, 0, 1, 0)};
    v1[7] = '{130, mk(0, 1, 21'd0, 2, 0, 0, 1, 0)};

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    num_steps = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("reset", 64'(get_obs()), 64'(0));
    rst = 1'b0;

    // Reference single pass, checked at table checkpoints
    prog(0, 5,   1, 0, 0,  0, 56);
    prog(1, 100, 1, 0, 29, 0, 56);
    prog(2, 10,  0, 1, 0,  0, 0);
    num_steps = 5'd3; loop_en = 1'b0; start = 1'b1;
    vi = 0;
    for (int t = 1; t <= 130; t++) begin
      tick();
      start = 1'b0;
      if (vi < 8 && v1[vi].t == t) begin
        chk($sformatf("t1_cyc%0d", t), 64'(get_obs()), 64'(v1[vi].e));
        vi++;
      end
    end

    // Zero-length pass from DONE leaves outputs alone
    num_steps = 5'd0; start = 1'b1; tick(); start = 1'b0;
    chk("t5_zero_len", 64'(get_obs()), 64'(mk(0, 1, 21'd0, 2, 0, 0, 1, 0)));

    // Abort with simultaneous start mid step 1
    num_steps = 5'd3; start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    chk("t4_mid", 64'(get_obs()), 64'(mk(1, 0, s1p, 1, 0, 1, 0, 0)));
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("t4_abort", 64'(get_obs()), 64'(0));
    repeat (3) tick();
    chk("t4_idle", 64'(get_obs()), 64'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_restart", 64'(get_obs()), 64'(mk(1, 0, s0p, 0, 1, 1, 0, 0)));

    // Synchronous reset mid HOLD
    repeat (8) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst", 64'(get_obs()), 64'(0));
    tick();
    chk("t6_rst_idle", 64'(get_obs()), 64'(0));

    // Table write landing on the entry edge of step 1: old data this pass, new next pass
    prog(0, 4, 1, 0, 1, 0, 0);
    prog(1, 4, 1, 0, 2, 0, 0);
    num_steps = 5'd2; loop_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = {16'd4, 1'b1, 1'b0, 7'd0, 7'd0, 7'd99};
    tick(); prog_we = 1'b0;
    m_pir[1] = 21'd99;
    chk("t6_entry_old", 64'(get_obs()), 64'(mk(1, 0, 21'd2, 1, 1, 1, 0, 0)));
    repeat (3) tick();
    chk("t6_active_old", 64'(get_obs()), 64'(mk(1, 0, 21'd2, 1, 0, 1, 0, 0)));
    tick();
    chk("t6_done_old", 64'(get_obs()), 64'(mk(1, 0, 21'd2, 1, 0, 0, 1, 0)));
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("t6_next_pass", 64'(get_obs()), 64'(mk(1, 0, 21'd99, 1, 1, 1, 0, 0)));

    // All-zero durations
    for (int i = 0; i < 4; i++) prog(i, 0, i[0], i[1], i + 1, 2 * i, 3 * i);
    run(4, 1'b0, 8, "t2_zero_dur", -1);

    // Loop mode, with an ignored start at cycle 21
    prog(0, 3, 1, 0, 10, 0, 0);
    prog(1, 3, 0, 1, 0, 20, 0);
    run(2, 1'b1, 40, "t3_loop", 20);
    chk("t3_loop_cnt", 64'(loop_cnt), 64'(6));
    prog(0, 0, 1, 0, 5, 5, 5);
    run(1, 1'b1, 300, "t3_sat", -1);
    chk("t3_sat_cnt", 64'(loop_cnt), 64'(255));

    // num_steps above DEPTH clamps to a full table
    for (int i = 0; i < 16; i++)
      prog(i, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
           $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    run(20, 1'b0, 70, "t5_clamp", -1);

    // Randomized programs and modes
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < 16; i++)
        prog(i, $urandom_range(0, 5), 1'($urandom), 1'($urandom),
             $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
      run(n, 1'($urandom), 60, $sformatf("rand%0d", it), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
